// File: rtl/tohost_pkg.sv
// Shared definitions for the riscv-tests tohost/console monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: monitor state enum, default register addresses, PASS result encoding.
package tohost_pkg;

   // RUN is the only non-terminal state; the others hold until reset.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_TOHOST_ADDR  = 32'h0000_1000;
   localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_1004;

   // riscv-tests convention: (test_num << 1) | 1 reports a failure, and 1 alone is a pass.
   localparam logic [31:0] PASS_CODE = 32'h0000_0001;

endpackage

// File: rtl/tohost_watchdog.sv
// Saturating cycle counter with optional expiry compare for the tohost monitor.
// Latency: count updates one edge after count_en; expired is combinational from count.
// Backpressure: none; count_en alone gates counting.
// Ports: clk, rst (async active-high), count_en, count[31:0], expired.
// Macro TOHOST_TIMEOUT_EN: when undefined, expired is tied low and TIMEOUT_CYCLES is inert.
module tohost_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_en,
   output logic [31:0] count,
   output logic        expired
);

   // Holds at all-ones rather than wrapping, so a very long run never looks fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (count_en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

`ifdef TOHOST_TIMEOUT_EN
   assign expired = (count >= 32'(TIMEOUT_CYCLES));
`else
   // The limit stays referenced so builds without the compare remain warning-free.
   logic unused_limit;
   assign unused_limit = ^TIMEOUT_CYCLES;
   assign expired      = 1'b0;
`endif

endmodule

// File: rtl/tohost_monitor.sv
// Watches CPU stores for riscv-tests tohost results and console putchar writes.
// Latency: halted/pass/fail/timeout and char_valid register one edge after acceptance.
// Backpressure: none; wr_ready is high whenever rst is low, so every store is taken.
// Ports: clk, rst (async active-high); wr_valid/wr_ready/wr_addr/wr_data/wr_strb store bus;
//        halted, pass, fail, timeout, test_num[30:0] result; char_valid, char_data[7:0] console;
//        cycle_count[31:0] cycles spent in RUN since reset release.
// Macro TOHOST_TIMEOUT_EN: enables the watchdog transition into TIMEOUT.
module tohost_monitor
   import tohost_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
   parameter logic [31:0] CONSOLE_ADDR   = DEFAULT_CONSOLE_ADDR,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   output logic        halted,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [30:0] test_num,
   output logic        char_valid,
   output logic [7:0]  char_data,
   output logic [31:0] cycle_count
);

   state_t state;

   logic accept;
   logic tohost_hit;
   logic pass_hit;
   logic fail_hit;
   logic char_hit;
   logic expired;
   logic leave_run;
   logic count_en;

   // Derived straight from rst so it drops the instant reset asserts.
   assign wr_ready = ~rst;
   assign accept   = wr_valid & wr_ready;

   // Only full-word writes with bit 0 set carry a result; anything else is a no-op.
   assign tohost_hit = accept && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hF) && wr_data[0];
   assign pass_hit   = tohost_hit && (wr_data == PASS_CODE);
   assign fail_hit   = tohost_hit && (wr_data != PASS_CODE);
   assign char_hit   = accept && (wr_addr == CONSOLE_ADDR) && wr_strb[0];

   // The counter skips the edge that leaves RUN, so it freezes at the value
   // visible during the deciding cycle.
   assign leave_run = (state == ST_RUN) && (pass_hit || fail_hit || expired);
   assign count_en  = (state == ST_RUN) && !leave_run;

   tohost_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .count_en (count_en),
      .count    (cycle_count),
      .expired  (expired)
   );

   // Result FSM; a tohost result takes priority over an expiry in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         halted   <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
`ifdef TOHOST_TIMEOUT_EN
         timeout  <= 1'b0;
`endif
         test_num <= '0;
      end else if (state == ST_RUN) begin
         if (pass_hit) begin
            state  <= ST_PASS;
            halted <= 1'b1;
            pass   <= 1'b1;
         end else if (fail_hit) begin
            state    <= ST_FAIL;
            halted   <= 1'b1;
            fail     <= 1'b1;
            test_num <= wr_data[31:1];
         end
`ifdef TOHOST_TIMEOUT_EN
         else if (expired) begin
            state   <= ST_TIMEOUT;
            halted  <= 1'b1;
            timeout <= 1'b1;
         end
`endif
      end
   end

`ifndef TOHOST_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

   // Console strobe works in every state so post-mortem prints still appear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_valid <= 1'b0;
         char_data  <= '0;
      end else begin
         char_valid <= char_hit;
         if (char_hit) begin
            char_data <= wr_data[7:0];
         end
      end
   end

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor with a queue-based scoreboard.
// Stimulus pushes expected halt and console events; a negedge monitor pops and compares.
// Timeout expectations follow TOHOST_TIMEOUT_EN as defined for the build.
module tb_tohost_monitor;

   localparam logic [31:0] TOHOST  = 32'h0000_1000;
   localparam logic [31:0] CONSOLE = 32'h0000_1004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        halted, pass, fail, timeout;
   logic [30:0] test_num;
   logic        char_valid;
   logic [7:0]  char_data;
   logic [31:0] cycle_count;

   tohost_monitor #(
      .TOHOST_ADDR    (TOHOST),
      .CONSOLE_ADDR   (CONSOLE),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_strb     (wr_strb),
      .halted      (halted),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .test_num    (test_num),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   // Bench cycle index: equals the number of edges since reset release.
   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      logic        p;
      logic        f;
      logic        t;
      logic [30:0] tn;
      logic [31:0] cnt;
      int          rise;
   } halt_exp_t;

   halt_exp_t  hq[$];
   logic [7:0] cq[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the active edge.
   logic halted_q = 1'b0;
   always @(negedge clk) begin
      if (char_valid) begin
         if (cq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_char: got %0h, expected no strobe (t=%0t)", char_data, $time);
         end else begin
            logic [7:0] ec;
            ec = cq.pop_front();
            chk("char_data", {24'd0, char_data}, {24'd0, ec});
         end
      end
      if (halted && !halted_q) begin
         if (hq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_halt: got halted=1, expected 0 (t=%0t)", $time);
         end else begin
            halt_exp_t e;
            e = hq.pop_front();
            chk("halt_pass",    {31'd0, pass},     {31'd0, e.p});
            chk("halt_fail",    {31'd0, fail},     {31'd0, e.f});
            chk("halt_timeout", {31'd0, timeout},  {31'd0, e.t});
            chk("halt_testnum", {1'b0, test_num},  {1'b0, e.tn});
            chk("halt_count",   cycle_count,       e.cnt);
            chk("halt_latency", cyc,               e.rise);
         end
      end
      halted_q = halted;
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_halted"},  {31'd0, halted},     0);
      chk({tag, "_pass"},    {31'd0, pass},       0);
      chk({tag, "_fail"},    {31'd0, fail},       0);
      chk({tag, "_timeout"}, {31'd0, timeout},    0);
      chk({tag, "_testnum"}, {1'b0, test_num},    0);
      chk({tag, "_charv"},   {31'd0, char_valid}, 0);
      chk({tag, "_chard"},   {24'd0, char_data},  0);
      chk({tag, "_count"},   cycle_count,         0);
      chk({tag, "_ready"},   {31'd0, wr_ready},   0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_valid = 1'b0;
      #1;
      check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_release", {31'd0, wr_ready}, 1);
   endtask

   // Returns one time unit after the edge at which the bench cycle index reaches n.
   task automatic wait_until(input int n);
      int g;
      g = 0;
      while (cyc != n && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (cyc != n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_bound: got cycle %0d, expected %0d", cyc, n);
      end
   endtask

   // Presents one store; it is accepted on the next rising edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_strb  = s;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   initial begin
      // Power-on reset values.
      #2;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_por", {31'd0, wr_ready}, 1);

      // Ignored stores, then pass at cycle 50, then stores after leaving RUN.
      wait_until(10);
      store(TOHOST, 32'h1, 4'h3);
      store(TOHOST, 32'h2, 4'hF);
      store(32'h0000_2000, 32'h1, 4'hF);
      chk("ignored_halted", {31'd0, halted}, 0);
      chk("run_count", cycle_count, 13);
      wait_until(50);
      hq.push_back('{p: 1'b1, f: 1'b0, t: 1'b0, tn: 31'd0, cnt: 32'd50, rise: 51});
      store(TOHOST, 32'h1, 4'hF);
      store(TOHOST, 32'h7, 4'hF);
      cq.push_back(8'h5A);
      store(CONSOLE, 32'h5A, 4'h1);
      wait_until(58);
      chk("post_pass", {31'd0, pass}, 1);
      chk("post_fail", {31'd0, fail}, 0);
      chk("post_testnum", {1'b0, test_num}, 0);
      chk("post_count", cycle_count, 50);

      // Console character, masked console store, then fail with test 3.
      do_reset();
      wait_until(5);
      cq.push_back(8'h41);
      store(CONSOLE, 32'h41, 4'hF);
      store(CONSOLE, 32'h43, 4'hE);
      wait_until(10);
      chk("console_halted", {31'd0, halted}, 0);
      chk("console_pass", {31'd0, pass}, 0);
      wait_until(20);
      hq.push_back('{p: 1'b0, f: 1'b1, t: 1'b0, tn: 31'd3, cnt: 32'd20, rise: 21});
      store(TOHOST, 32'h7, 4'hF);

      // Async reset in FAIL while a console strobe is high.
      wait_until(25);
      wr_valid = 1'b1;
      wr_addr  = CONSOLE;
      wr_data  = 32'h42;
      wr_strb  = 4'h1;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      chk("pulse_before_rst", {31'd0, char_valid}, 1);
      chk("pulse_data", {24'd0, char_data}, 32'h42);
      rst = 1'b1;
      #1;
      check_reset_outputs("async");
      do_reset();
      wait_until(30);
      hq.push_back('{p: 1'b1, f: 1'b0, t: 1'b0, tn: 31'd0, cnt: 32'd30, rise: 31});
      store(TOHOST, 32'h1, 4'hF);
      wait_until(33);
      chk("rerun_pass", {31'd0, pass}, 1);

      // Idle run past the watchdog limit.
      do_reset();
`ifdef TOHOST_TIMEOUT_EN
      hq.push_back('{p: 1'b0, f: 1'b0, t: 1'b1, tn: 31'd0, cnt: 32'd100, rise: 101});
`endif
      wait_until(150);
`ifdef TOHOST_TIMEOUT_EN
      chk("idle_timeout", {31'd0, timeout}, 1);
      chk("idle_halted", {31'd0, halted}, 1);
      chk("idle_count", cycle_count, 100);
`else
      chk("idle_timeout", {31'd0, timeout}, 0);
      chk("idle_halted", {31'd0, halted}, 0);
      chk("idle_count", cycle_count, 150);
`endif

      // Pass store accepted in the expiry cycle wins over the watchdog.
      do_reset();
      wait_until(100);
      hq.push_back('{p: 1'b1, f: 1'b0, t: 1'b0, tn: 31'd0, cnt: 32'd100, rise: 101});
      store(TOHOST, 32'h1, 4'hF);
      wait_until(105);
      chk("race_pass", {31'd0, pass}, 1);
      chk("race_timeout", {31'd0, timeout}, 0);

      // Every expected event must have been observed.
      repeat (2) @(posedge clk);
      #1;
      chk("sb_halt_left", hq.size(), 0);
      chk("sb_char_left", cq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before bound");
      $fatal(1, "simulation time bound expired");
   end

endmodule

// File: doc/tohost_monitor.md
TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the word address of the riscv-tests result register.
REQ-002 SHALL have parameter CONSOLE_ADDR, default 32'h0000_1004, the word address of the putchar register.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, the watchdog limit in clk cycles after reset release.
REQ-004 Ports, in this order:
- clk  in  1  -- single clock; all state changes on its rising edge.
- rst  in  1  -- asynchronous, active-high reset.
- wr_valid  in  1  -- CPU data-bus store request.
- wr_ready  out  1  -- store accepted this cycle.
- wr_addr  in  32  -- store byte address.
- wr_data  in  32  -- store data.
- wr_strb  in  4  -- byte enables.
- halted  out  1  -- simulation end request.
- pass  out  1  -- test passed.
- fail  out  1  -- test failed.
- timeout  out  1  -- watchdog expired.
- test_num  out  31  -- failing test number.
- char_valid  out  1  -- one-cycle console character strobe.
- char_data  out  8  -- console character.
- cycle_count  out  32  -- cycles since reset release.

Function
REQ-005 SHALL drive wr_ready high in every cycle rst is low; a store is accepted when wr_valid and wr_ready are both high.
REQ-006 SHALL implement FSM states RUN, PASS, FAIL, TIMEOUT; the reset state is RUN; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-007 In RUN, an accepted store to TOHOST_ADDR with wr_strb=4'hF and wr_data=32'h1 SHALL move to PASS.
REQ-008 In RUN, an accepted store to TOHOST_ADDR with wr_strb=4'hF, wr_data[0]=1 and wr_data!=1 SHALL move to FAIL and register test_num=wr_data[31:1].
REQ-009 Stores to TOHOST_ADDR with wr_data[0]=0 or wr_strb!=4'hF SHALL be accepted and ignored.
REQ-010 An accepted store to CONSOLE_ADDR with wr_strb[0]=1 SHALL pulse char_valid for exactly one cycle, the cycle after acceptance, with char_data=wr_data[7:0], in any state.
REQ-011 Stores to any other address SHALL be accepted and ignored.
REQ-012 halted SHALL be high in PASS, FAIL and TIMEOUT; pass, fail and timeout SHALL each be high only in their own state.
REQ-013 halted, pass and fail SHALL assert the cycle after the accepting edge (1-cycle latency).
REQ-014 In RUN, cycle_count SHALL increment by one per cycle, saturate at 32'hFFFF_FFFF, and freeze on leaving RUN.
REQ-015 Accepted stores after leaving RUN SHALL NOT change state, test_num or cycle_count.

Reset
REQ-016 While rst is high, outputs SHALL be: state=RUN, halted=0, pass=0, fail=0, timeout=0, test_num=0, char_valid=0, char_data=0, cycle_count=0, wr_ready=0.
REQ-017 Asserting rst mid-operation, including in a terminal state or during a char_valid pulse, SHALL return all outputs to reset values immediately, without waiting for a clk edge.

Configuration
REQ-018 With macro TOHOST_TIMEOUT_EN defined:
- when cycle_count reaches TIMEOUT_CYCLES in RUN, the FSM SHALL move to TIMEOUT on the next edge;
- if a qualifying tohost store is accepted in that same cycle, the store SHALL win.
REQ-019 Without TOHOST_TIMEOUT_EN:
- the TIMEOUT state SHALL be unreachable;
- timeout SHALL be tied to 0;
- TIMEOUT_CYCLES SHALL have no effect.

Structure
REQ-020 The state enum, the default TOHOST_ADDR and CONSOLE_ADDR values, and the PASS encoding constant 32'h1 SHALL reside in shared package tohost_pkg.
REQ-021 The saturating cycle counter and timeout compare SHALL be a sub-module, tohost_watchdog, instantiated once; the compare logic is present only under TOHOST_TIMEOUT_EN.

Verification
REQ-022 A bench SHALL cover these directed scenarios:
- Store TOHOST_ADDR, data 32'h1, strb F, at cycle 50 -> pass=1 and halted=1 at cycle 51; cycle_count frozen at 50.
- Store TOHOST_ADDR, data 32'h0000_0007 -> fail=1, test_num=3, halted=1.
- Store CONSOLE_ADDR, data 32'h41 -> exactly one char_valid pulse with char_data=8'h41; state stays RUN.
- Store TOHOST_ADDR, data 32'h1, strb 4'h3, then data 32'h2, strb F -> both ignored, halted=0; then pass store, then fail store -> pass stays 1, fail stays 0.
- TOHOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, no stores -> timeout=1 and halted=1 after cycle 100; repeat with a pass store in the expiry cycle -> pass=1, timeout=0.
- Assert rst asynchronously while in FAIL -> all outputs return to reset values before the next clk edge; after release, a pass store yields pass=1.
